vga_timing_ctrl: RTL and testbench
==================================

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 SHALL have parameter HDISP, default 800, active pixels per line.
REQ-002 SHALL have parameter VDISP, default 480, active lines per frame.
REQ-003 SHALL have parameters HFP/HPULSE/HBP, defaults 40/48/40, horizontal front porch, sync and back porch in pixels.
REQ-004 SHALL have parameters VFP/VPULSE/VBP, defaults 13/3/29, vertical front porch, sync and back porch in lines.
REQ-005 SHALL have parameters HS_POL/VS_POL, default 0/0, asserted sync level.
REQ-006 SHALL have parameters RGB_W, default 24, pixel width, and GRID_LOG2, default 4, grid pitch as log2 pixels.
REQ-007 SHALL have ports: pixel_clk  in  1  sole clock. pixel_rst_n  in  1  synchronous active-low reset.
REQ-008 SHALL have ports: mode  in  2  0=grid, 1=colour bars, 2=FIFO stream, 3=solid. solid_rgb  in  RGB_W  solid-mode colour.
REQ-009 SHALL have ports: fifo_rdata  in  RGB_W  show-ahead FIFO head. fifo_empty  in  1. fifo_read  out  1  pop strobe.
REQ-010 SHALL have ports: hs, vs, blank  out  1 each. rgb  out  RGB_W. x  out  clog2(HDISP). y  out  clog2(VDISP).
REQ-011 SHALL have ports: frame_start  out  1  one-cycle pulse. underflow  out  1  sticky. underflow_clr  in  1.

Function
REQ-012 SHALL run h counter 0..HTOT-1 (HTOT=HFP+HPULSE+HBP+HDISP) and v counter 0..VTOT-1; v increments only on h wrap; v wraps to 0 on h wrap when v==VTOT-1.
REQ-013 SHALL order each line/frame as front porch, sync, back porch, active; active when h>=HFP+HPULSE+HBP and v>=VFP+VPULSE+VBP.
REQ-014 SHALL drive hs=HS_POL for h in [HFP, HFP+HPULSE), else !HS_POL; same rule for vs on v.
REQ-015 SHALL drive blank=1 exactly during active region, so blank is an active-video enable.
REQ-016 SHALL register hs, vs, blank, rgb, x, y with one cycle latency from counter state, all mutually aligned.
REQ-017 SHALL drive x, y as active-region coordinates; x, y, rgb SHALL be 0 outside active.
REQ-018 SHALL latch mode and solid_rgb only when h==0 and v==0; mid-frame changes SHALL take effect next frame.
REQ-019 SHALL pulse frame_start for one cycle on the registered cycle where h==0 and v==0.
REQ-020 Grid: rgb all-ones when x[GRID_LOG2-1:0] or y[GRID_LOG2-1:0] is all-ones, else 0.
REQ-021 Bars: 8 vertical bars of width HDISP/8, left to right white, yellow, cyan, green, magenta, red, blue, black; remainder pixels black.
REQ-022 Solid: rgb = latched solid_rgb.
REQ-023 Stream: fifo_read SHALL be combinational, 1 iff active and latched mode==2 and !fifo_empty; rgb registers fifo_rdata on that cycle.
REQ-024 Stream with fifo_empty during active: fifo_read=0, rgb=0, underflow SHALL set next cycle.
REQ-025 underflow SHALL hold until underflow_clr; simultaneous set and clear SHALL leave it set.
REQ-026 fifo_read SHALL be 0 in every non-stream mode and outside active.

Reset
REQ-027 While pixel_rst_n==0 at a pixel_clk edge: h=v=0, mode latch=0, hs=!HS_POL, vs=!VS_POL, blank=0, rgb=0, x=y=0, frame_start=0, underflow=0.
REQ-028 fifo_read SHALL be 0 during reset; release mid-frame SHALL restart at h=v=0 with first frame_start on the first cycle after release.

Structure
REQ-029 SHALL place the mode enum (MODE_GRID, MODE_BARS, MODE_STREAM, MODE_SOLID) and the 8 bar colour constants in a shared package video_pkg.
REQ-030 SHALL use one sub-module, vga_pattern_gen, combinationally mapping (mode, x, y, solid_rgb, fifo_rdata, fifo_empty) to pixel value.

Verification (HDISP=8, VDISP=4, HFP=HPULSE=HBP=2, VFP=VPULSE=VBP=1, RGB_W=24)
REQ-031 Reset then run 2 frames -> HTOT=14, VTOT=7; hs low for h=2,3; vs low on v=1; blank high 8 cycles per line on v=3..6; frame_start every 98 cycles.
REQ-032 Mode 0, GRID_LOG2=1 -> rgb=FFFFFF at odd x or odd y, 000000 elsewhere.
REQ-033 Mode 1 -> bars 1 pixel wide: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
REQ-034 Mode 2, FIFO preloaded 0x000001..0x000020 -> 32 pops in active only, rgb matches order; then empty -> rgb=0, underflow=1 until underflow_clr.
REQ-035 Change mode 0->3 mid-frame -> grid continues until next frame_start, then solid_rgb everywhere active.
REQ-036 Drop pixel_rst_n for 1 cycle at h=5,v=4 -> all outputs at reset values, counters restart at 0, underflow cleared.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video definitions: pattern mode encoding and colour-bar palette.
// Bar colours are {r,g,b} channel-enable bits, expanded to full pixel width by the user.
package video_pkg;

    typedef enum logic [1:0] {
        MODE_GRID   = 2'd0,
        MODE_BARS   = 2'd1,
        MODE_STREAM = 2'd2,
        MODE_SOLID  = 2'd3
    } mode_t;

    localparam logic [2:0] BAR_WHITE   = 3'b111;
    localparam logic [2:0] BAR_YELLOW  = 3'b110;
    localparam logic [2:0] BAR_CYAN    = 3'b011;
    localparam logic [2:0] BAR_GREEN   = 3'b010;
    localparam logic [2:0] BAR_MAGENTA = 3'b101;
    localparam logic [2:0] BAR_RED     = 3'b100;
    localparam logic [2:0] BAR_BLUE    = 3'b001;
    localparam logic [2:0] BAR_BLACK   = 3'b000;

    // Left-to-right bar order.
    function automatic logic [2:0] bar_colour(input logic [2:0] idx);
        logic [2:0] c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// Maps latched mode and active-area coordinates to a pixel value.
// Latency: purely combinational; backpressure: none (stream mode shows black when the FIFO is empty).
module vga_pattern_gen
    import video_pkg::*;
#(
    parameter int HDISP     = 800,
    parameter int RGB_W     = 24,
    parameter int GRID_LOG2 = 4,
    parameter int XW        = 10,
    parameter int YW        = 9
) (
    input  mode_t             mode,
    input  logic [XW-1:0]     x,
    input  logic [YW-1:0]     y,
    input  logic [RGB_W-1:0]  solid_rgb,
    input  logic [RGB_W-1:0]  fifo_rdata,
    input  logic              fifo_empty,
    output logic [RGB_W-1:0]  pixel
);

    localparam int BAR_W = (HDISP / 8 > 0) ? HDISP / 8 : 1;
    localparam int CW    = RGB_W / 3;
    localparam logic [XW-1:0] XMASK = XW'((1 << GRID_LOG2) - 1);
    localparam logic [YW-1:0] YMASK = YW'((1 << GRID_LOG2) - 1);

    function automatic logic [RGB_W-1:0] expand(input logic [2:0] c);
        logic [RGB_W-1:0] p;
        p = '0;
        p[3*CW-1 -: CW] = {CW{c[2]}};
        p[2*CW-1 -: CW] = {CW{c[1]}};
        p[CW-1   -: CW] = {CW{c[0]}};
        return p;
    endfunction

    logic [31:0] bar_idx;
    logic        grid_on;

    assign bar_idx = 32'(x) / 32'(BAR_W);
    assign grid_on = ((x & XMASK) == XMASK) || ((y & YMASK) == YMASK);

    always_comb begin
        pixel = '0;
        case (mode)
            MODE_GRID:   if (grid_on) pixel = '1;
            // Pixels past the eighth bar (HDISP not a multiple of 8) stay black.
            MODE_BARS:   if (bar_idx < 32'd8) pixel = expand(bar_colour(bar_idx[2:0]));
            MODE_STREAM: if (!fifo_empty) pixel = fifo_rdata;
            MODE_SOLID:  pixel = solid_rgb;
            default:     pixel = '0;
        endcase
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator with grid/bars/stream/solid pattern source.
// Latency: 1 cycle from counters to hs/vs/blank/rgb/x/y; fifo_read combinational; backpressure: none, empty FIFO gives black and sticky underflow.
module vga_timing_ctrl
    import video_pkg::*;
#(
    parameter int HDISP     = 800,
    parameter int VDISP     = 480,
    parameter int HFP       = 40,
    parameter int HPULSE    = 48,
    parameter int HBP       = 40,
    parameter int VFP       = 13,
    parameter int VPULSE    = 3,
    parameter int VBP       = 29,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int RGB_W     = 24,
    parameter int GRID_LOG2 = 4
) (
    input  logic                       pixel_clk,
    input  logic                       pixel_rst_n,
    input  logic [1:0]                 mode,
    input  logic [RGB_W-1:0]           solid_rgb,
    input  logic [RGB_W-1:0]           fifo_rdata,
    input  logic                       fifo_empty,
    output logic                       fifo_read,
    output logic                       hs,
    output logic                       vs,
    output logic                       blank,
    output logic [RGB_W-1:0]           rgb,
    output logic [$clog2(HDISP)-1:0]   x,
    output logic [$clog2(VDISP)-1:0]   y,
    output logic                       frame_start,
    output logic                       underflow,
    input  logic                       underflow_clr
);

    localparam int HTOT   = HFP + HPULSE + HBP + HDISP;
    localparam int VTOT   = VFP + VPULSE + VBP + VDISP;
    localparam int HSTART = HFP + HPULSE + HBP;
    localparam int VSTART = VFP + VPULSE + VBP;
    localparam int HW     = $clog2(HTOT);
    localparam int VW     = $clog2(VTOT);
    localparam int XW     = $clog2(HDISP);
    localparam int YW     = $clog2(VDISP);

    logic [HW-1:0]    h_cnt;
    logic [VW-1:0]    v_cnt;
    mode_t            mode_q;
    logic [RGB_W-1:0] solid_q;

    logic             h_wrap, v_wrap, frame_origin, active;
    logic             h_sync, v_sync, stream_sel, uf_set;
    logic [XW-1:0]    x_nxt;
    logic [YW-1:0]    y_nxt;
    logic [RGB_W-1:0] pixel;

    assign h_wrap       = (h_cnt == HW'(HTOT - 1));
    assign v_wrap       = (v_cnt == VW'(VTOT - 1));
    assign frame_origin = (h_cnt == '0) && (v_cnt == '0);
    assign active       = (h_cnt >= HW'(HSTART)) && (v_cnt >= VW'(VSTART));
    assign h_sync       = (h_cnt >= HW'(HFP)) && (h_cnt < HW'(HFP + HPULSE));
    assign v_sync       = (v_cnt >= VW'(VFP)) && (v_cnt < VW'(VFP + VPULSE));

    // Coordinates are only meaningful inside the active area; outputs mask them elsewhere.
    assign x_nxt = XW'(h_cnt - HW'(HSTART));
    assign y_nxt = YW'(v_cnt - VW'(VSTART));

    assign stream_sel = active && (mode_q == MODE_STREAM);
    assign fifo_read  = pixel_rst_n && stream_sel && !fifo_empty;
    assign uf_set     = stream_sel && fifo_empty;

    vga_pattern_gen #(
        .HDISP     (HDISP),
        .RGB_W     (RGB_W),
        .GRID_LOG2 (GRID_LOG2),
        .XW        (XW),
        .YW        (YW)
    ) u_pattern (
        .mode       (mode_q),
        .x          (x_nxt),
        .y          (y_nxt),
        .solid_rgb  (solid_q),
        .fifo_rdata (fifo_rdata),
        .fifo_empty (fifo_empty),
        .pixel      (pixel)
    );

    always_ff @(posedge pixel_clk) begin
        if (!pixel_rst_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            mode_q      <= MODE_GRID;
            solid_q     <= '0;
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            blank       <= 1'b0;
            rgb         <= '0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
            // Pattern selection only changes at the frame origin so a frame is never mixed.
            if (frame_origin) begin
                mode_q  <= mode_t'(mode);
                solid_q <= solid_rgb;
            end
            hs          <= h_sync ? HS_POL : ~HS_POL;
            vs          <= v_sync ? VS_POL : ~VS_POL;
            blank       <= active;
            rgb         <= active ? pixel : '0;
            x           <= active ? x_nxt : '0;
            y           <= active ? y_nxt : '0;
            frame_start <= frame_origin;
            underflow   <= uf_set | (underflow & ~underflow_clr);
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl: raster-position reference model feeds an expected queue,
// a negedge monitor pops and compares every registered output plus the combinational pop strobe.
module tb_vga_timing_ctrl;

    localparam int HTOT  = 14;
    localparam int VTOT  = 7;
    localparam int FRAME = HTOT * VTOT;
    localparam int HACT0 = 6;
    localparam int VACT0 = 3;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        blank;
        logic        fs;
        logic        uf;
        logic [23:0] rgb;
        logic [2:0]  x;
        logic [1:0]  y;
    } rec_t;

    logic        pixel_clk     = 1'b0;
    logic        pixel_rst_n   = 1'b0;
    logic [1:0]  mode          = 2'd0;
    logic [23:0] solid_rgb     = 24'h0;
    logic [23:0] fifo_rdata    = 24'h0;
    logic        fifo_empty    = 1'b1;
    logic        underflow_clr = 1'b0;
    logic        fifo_read, hs, vs, blank, frame_start, underflow;
    logic [23:0] rgb;
    logic [2:0]  x;
    logic [1:0]  y;

    int checks = 0;
    int errors = 0;

    vga_timing_ctrl #(
        .HDISP(8), .VDISP(4), .HFP(2), .HPULSE(2), .HBP(2),
        .VFP(1), .VPULSE(1), .VBP(1), .HS_POL(1'b0), .VS_POL(1'b0),
        .RGB_W(24), .GRID_LOG2(1)
    ) dut (
        .pixel_clk(pixel_clk), .pixel_rst_n(pixel_rst_n), .mode(mode),
        .solid_rgb(solid_rgb), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
        .fifo_read(fifo_read), .hs(hs), .vs(vs), .blank(blank), .rgb(rgb),
        .x(x), .y(y), .frame_start(frame_start), .underflow(underflow),
        .underflow_clr(underflow_clr)
    );

    always #5 pixel_clk = ~pixel_clk;

    // ---------------- external FIFO emulation ----------------
    logic [23:0] dq[$];
    logic [23:0] exp_q[$];
    logic        fifo_rd_s;

    function automatic void refresh();
        fifo_empty = (dq.size() == 0);
        fifo_rdata = fifo_empty ? 24'hDEAD5A : dq[0];
    endfunction

    task automatic push_fifo(input logic [23:0] d);
        dq.push_back(d);
        exp_q.push_back(d);
        refresh();
    endtask

    initial forever begin
        @(negedge pixel_clk);
        fifo_rd_s = fifo_read;
        @(posedge pixel_clk);
        #1;
        if (fifo_rd_s && dq.size() > 0) dq.delete(0);
        refresh();
    end

    // ---------------- reference model ----------------
    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    int          k       = 0;
    logic [1:0]  m_mode  = 2'd0;
    logic [23:0] m_solid = 24'h0;
    bit          m_uf    = 1'b0;
    bit          started = 1'b0;
    rec_t        exp_rec[$];

    function automatic bit is_active(input int pos);
        return ((pos % HTOT) >= HACT0) && ((pos / HTOT) >= VACT0);
    endfunction

    always @(posedge pixel_clk) begin
        rec_t e;
        int   p, h, v, xx, yy;
        bit   set;
        e = '0;
        started = 1'b1;
        if (!pixel_rst_n) begin
            e.hs = 1'b1; e.vs = 1'b1;
            k = 0; m_uf = 1'b0; m_mode = 2'd0; m_solid = 24'h0;
        end else begin
            p = k % FRAME; h = p % HTOT; v = p / HTOT;
            if (p == 0) begin m_mode = mode; m_solid = solid_rgb; end
            set = 1'b0;
            e.hs = !(h == 2 || h == 3);
            e.vs = (v != 1);
            e.fs = (p == 0);
            if (is_active(p)) begin
                xx = h - HACT0; yy = v - VACT0;
                e.blank = 1'b1;
                e.x = 3'(xx);
                e.y = 2'(yy);
                case (m_mode)
                    2'd0: e.rgb = ((xx % 2) == 1 || (yy % 2) == 1) ? 24'hFFFFFF : 24'h0;
                    2'd1: e.rgb = bar_tab[xx];
                    2'd2: if (exp_q.size() > 0) e.rgb = exp_q.pop_front(); else set = 1'b1;
                    default: e.rgb = m_solid;
                endcase
            end
            m_uf = set || (m_uf && !underflow_clr);
            e.uf = m_uf;
            k++;
        end
        exp_rec.push_back(e);
    end

    // ---------------- monitor ----------------
    always @(negedge pixel_clk) begin
        rec_t e, got;
        bit   exp_rd;
        if (started) begin
            got = '{hs, vs, blank, frame_start, underflow, rgb, x, y};
            checks++;
            if (exp_rec.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty at k=%0d: no expected record for observed output", k);
            end else begin
                e = exp_rec.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs k=%0d got hs=%b vs=%b blank=%b fs=%b uf=%b rgb=%h x=%0d y=%0d want hs=%b vs=%b blank=%b fs=%b uf=%b rgb=%h x=%0d y=%0d",
                             k, got.hs, got.vs, got.blank, got.fs, got.uf, got.rgb, got.x, got.y,
                             e.hs, e.vs, e.blank, e.fs, e.uf, e.rgb, e.x, e.y);
                end
            end
            exp_rd = pixel_rst_n && is_active(k % FRAME) && (m_mode == 2'd2) && (exp_q.size() > 0);
            checks++;
            if (fifo_read !== exp_rd) begin
                errors++;
                $display("FAIL fifo_read k=%0d got %b want %b", k, fifo_read, exp_rd);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge pixel_clk);
        #2;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_pos(input int target);
        int g;
        g = 0;
        do begin
            tick();
            g++;
        end while ((k % FRAME) != target && g < 4 * FRAME);
        checks++;
        if ((k % FRAME) != target) begin
            errors++;
            $display("FAIL wait_pos got %0d want %0d", k % FRAME, target);
        end
    endtask

    initial begin
        refresh();
        run(3);
        pixel_rst_n = 1'b1;
        solid_rgb = 24'($urandom);
        run(2 * FRAME);

        wait_pos(50); mode = 2'd1; run(2 * FRAME);
        wait_pos(50); mode = 2'd0; run(FRAME);
        wait_pos(40); mode = 2'd3; solid_rgb = 24'($urandom); run(FRAME);
        wait_pos(50); solid_rgb = 24'($urandom); run(FRAME);

        for (int i = 1; i <= 32; i++) push_fifo(24'(i));
        wait_pos(60); mode = 2'd2;
        run(2 * FRAME);
        wait_pos(10); underflow_clr = 1'b1; tick(); underflow_clr = 1'b0;
        wait_pos(50); underflow_clr = 1'b1; tick(); underflow_clr = 1'b0;
        run(FRAME);

        for (int c = 0; c < 8 * FRAME; c++) begin
            if ($urandom_range(0, 7) == 0) push_fifo(24'($urandom));
            underflow_clr = ($urandom_range(0, 39) == 0);
            if ((k % FRAME) == 50) begin
                mode = 2'($urandom_range(0, 3));
                solid_rgb = 24'($urandom);
            end
            tick();
        end
        underflow_clr = 1'b0;

        mode = 2'd2;
        wait_pos(0);
        wait_pos(45);
        for (int i = 0; i < 5; i++) push_fifo(24'($urandom));
        wait_pos(50);
        pixel_rst_n = 1'b0; tick(); pixel_rst_n = 1'b1;
        run(3 * FRAME);

        wait_pos(61);
        pixel_rst_n = 1'b0; tick(); pixel_rst_n = 1'b1;
        run(FRAME + 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout at k=%0d", k);
        $fatal(1, "watchdog");
    end

endmodule
